// File: rtl/proc_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit teaching processor.
// Optional build macro PROC_HALT_EN: opcode 111 halts the core until reset (else NOP).
module proc_control_fsm #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [15:0] mem_rdata,
  input  logic        g_nonzero,
  output logic        rb_write,
  output logic [2:0]  rb_sel_read,
  output logic [2:0]  rb_sel_write,
  output logic        rb_incr_pc,
  output logic [1:0]  bus_sel,
  output logic        a_load,
  output logic        g_load,
  output logic        alu_op,
  output logic        addr_load,
  output logic        dout_load,
  output logic        mem_write,
  output logic        done,
  output logic        halted
);

  typedef enum logic [3:0] {
    StIdle, StFAddr, StFWait, StFLoad, StEx1, StEx2, StEx3, StEWait
`ifdef PROC_HALT_EN
    , StHalt
`endif
  } state_e;

  typedef enum logic [2:0] {
    OpMv, OpMvi, OpAdd, OpSub, OpLd, OpSt, OpMvnz, OpSpc
  } op_e;

  localparam logic [2:0] WaitInit = (MEM_WAIT == 0) ? 3'd0 : 3'(MEM_WAIT - 1);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  cnt_q, cnt_d;
  op_e         op;
  logic [2:0]  rx, ry;
  logic        finish, mem_access;
  logic        unused_ir;

  assign op        = op_e'(ir_q[15:13]);
  assign rx        = ir_q[12:10];
  assign ry        = ir_q[9:7];
  assign unused_ir = ^ir_q[6:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    cnt_d        = cnt_q;
    rb_write     = 1'b0;
    rb_sel_read  = 3'd0;
    rb_sel_write = 3'd0;
    rb_incr_pc   = 1'b0;
    bus_sel      = 2'd0;
    a_load       = 1'b0;
    g_load       = 1'b0;
    alu_op       = 1'b0;
    addr_load    = 1'b0;
    dout_load    = 1'b0;
    mem_write    = 1'b0;
    done         = 1'b0;
    halted       = 1'b0;
    finish       = 1'b0;
    mem_access   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFAddr;
      end
      StFAddr: begin
        rb_sel_read = 3'd7;
        addr_load   = 1'b1;
        rb_incr_pc  = 1'b1;
        if (MEM_WAIT == 0) begin
          state_d = StFLoad;
        end else begin
          state_d = StFWait;
          cnt_d   = WaitInit;
        end
      end
      StFWait: begin
        if (cnt_q == 3'd0) state_d = StFLoad;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StEWait: begin
        if (cnt_q == 3'd0) state_d = StEx2;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StFLoad: begin
        ir_d    = mem_rdata;
        state_d = StEx1;
      end
      StEx1: begin
        unique case (op)
          OpMv: begin
            rb_sel_read = ry;
            rb_write    = 1'b1;
            finish      = 1'b1;
          end
          OpMvi: begin
            // Immediate word follows the instruction: fetch it through the PC.
            rb_sel_read = 3'd7;
            addr_load   = 1'b1;
            rb_incr_pc  = 1'b1;
            mem_access  = 1'b1;
          end
          OpAdd, OpSub: begin
            rb_sel_read = rx;
            a_load      = 1'b1;
            state_d     = StEx2;
          end
          OpLd: begin
            rb_sel_read = ry;
            addr_load   = 1'b1;
            mem_access  = 1'b1;
          end
          OpSt: begin
            rb_sel_read = ry;
            addr_load   = 1'b1;
            state_d     = StEx2;
          end
          OpMvnz: begin
            rb_sel_read = ry;
            rb_write    = g_nonzero;
            finish      = 1'b1;
          end
          OpSpc: begin
`ifdef PROC_HALT_EN
            state_d = StHalt;
`else
            finish  = 1'b1;
`endif
          end
          default: state_d = StIdle;
        endcase
      end
      StEx2: begin
        unique case (op)
          OpMvi, OpLd: begin
            bus_sel  = 2'd1;
            rb_write = 1'b1;
            finish   = 1'b1;
          end
          OpAdd, OpSub: begin
            rb_sel_read = ry;
            g_load      = 1'b1;
            alu_op      = ir_q[13];
            state_d     = StEx3;
          end
          OpSt: begin
            rb_sel_read = rx;
            dout_load   = 1'b1;
            mem_write   = 1'b1;
            finish      = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end
      StEx3: begin
        bus_sel  = 2'd2;
        rb_write = 1'b1;
        finish   = 1'b1;
      end
`ifdef PROC_HALT_EN
      StHalt: halted = 1'b1;
`endif
      default: state_d = StIdle;
    endcase

    if (rb_write) rb_sel_write = rx;

    if (mem_access) begin
      state_d = (MEM_WAIT == 0) ? StEx2 : StEWait;
      cnt_d   = WaitInit;
    end

    if (finish) begin
      done    = 1'b1;
      state_d = run ? StFAddr : StIdle;
    end
  end

endmodule
